// File: rtl/bsg_noc_link_delay_buffer.sv
// Programmable-latency, in-order flit buffer for one ready_and NoC link.
// It can bypass the buffer combinationally, and it counts output handshakes and stall cycles.
module bsg_noc_link_delay_buffer #(
  parameter int width_p       = 32,
  parameter int els_p         = 8,
  parameter int max_delay_p   = 15,
  parameter int count_width_p = 16,
  localparam int delay_width_lp = $clog2(max_delay_p+1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [delay_width_lp-1:0] delay_i,
  input  logic                      bypass_i,
  input  logic                      clear_i,
  input  logic                      v_i,
  input  logic [width_p-1:0]        data_i,
  output logic                      ready_and_o,
  output logic                      v_o,
  output logic [width_p-1:0]        data_o,
  input  logic                      ready_and_i,
  output logic [count_width_p-1:0]  flit_count_o,
  output logic [count_width_p-1:0]  stall_count_o
);

  localparam int addr_width_lp = $clog2(els_p);
  localparam int ptr_width_lp  = addr_width_lp + 1;

  typedef enum logic [1:0] {NORMAL, DRAIN, BYPASS} state_e;

  function automatic logic [delay_width_lp-1:0] clamp_delay(input logic [delay_width_lp-1:0] d);
    logic [delay_width_lp:0] lim;
    lim = (delay_width_lp+1)'(max_delay_p);
    if ({1'b0, d} > lim) return lim[delay_width_lp-1:0];
    return d;
  endfunction

  function automatic logic [count_width_p-1:0] sat_inc(input logic [count_width_p-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_e                    state_r;
  logic [ptr_width_lp-1:0]   rd_ptr_r, wr_ptr_r;
  logic [width_p-1:0]        data_mem [els_p];
  logic [delay_width_lp-1:0] timer_r  [els_p];

  logic [addr_width_lp-1:0] rd_idx, wr_idx;
  logic empty, full, head_ready, enq, deq;

  assign rd_idx = rd_ptr_r[addr_width_lp-1:0];
  assign wr_idx = wr_ptr_r[addr_width_lp-1:0];
  assign empty  = (rd_ptr_r == wr_ptr_r);
  // Extra pointer MSB differs only when the writer has lapped the reader.
  assign full   = (rd_ptr_r[addr_width_lp] != wr_ptr_r[addr_width_lp]) && (rd_idx == wr_idx);
  assign head_ready = !empty && (timer_r[rd_idx] == '0);

  always_comb begin
    v_o         = 1'b0;
    data_o      = '0;
    ready_and_o = 1'b0;
    if (reset_n_i) begin
      case (state_r)
        BYPASS: begin
          v_o         = v_i;
          data_o      = data_i;
          ready_and_o = ready_and_i;
        end
        DRAIN: begin
          v_o    = head_ready;
          data_o = data_mem[rd_idx];
        end
        default: begin
          v_o         = head_ready;
          data_o      = data_mem[rd_idx];
          ready_and_o = !full;
        end
      endcase
    end
  end

  assign enq = v_i && ready_and_o && (state_r == NORMAL);
  assign deq = v_o && ready_and_i && (state_r != BYPASS);

  always_ff @(posedge clk_i) begin
    if (enq) data_mem[wr_idx] <= data_i;
  end

  // Control state: pointers, timers, mode and counters.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r       <= NORMAL;
      rd_ptr_r      <= '0;
      wr_ptr_r      <= '0;
      flit_count_o  <= '0;
      stall_count_o <= '0;
      for (int i = 0; i < els_p; i++) timer_r[i] <= '0;
    end else begin
      for (int i = 0; i < els_p; i++) begin
        if (enq && (wr_idx == addr_width_lp'(i)))
          timer_r[i] <= clamp_delay(delay_i);
        else if (timer_r[i] != '0)
          timer_r[i] <= timer_r[i] - 1'b1;
      end
      if (enq) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (deq) rd_ptr_r <= rd_ptr_r + 1'b1;

      case (state_r)
        NORMAL: if (bypass_i) state_r <= (empty && !enq) ? BYPASS : DRAIN;
        DRAIN: begin
          if (!bypass_i)  state_r <= NORMAL;
          else if (empty) state_r <= BYPASS;
        end
        BYPASS:  if (!bypass_i) state_r <= NORMAL;
        default: state_r <= NORMAL;
      endcase

      if (clear_i) begin
        flit_count_o  <= '0;
        stall_count_o <= '0;
      end else begin
        if (v_o && ready_and_i)  flit_count_o  <= flit_count_o + 1'b1;
        if (v_o && !ready_and_i) stall_count_o <= sat_inc(stall_count_o);
      end
    end
  end

endmodule
